sram2sraml_wbuf: RTL and testbench

//  Data-side SRAM -> SRAM-like bridge with a posted-write buffer. Sits between the CPU
//  MEM stage (SRAM-style, stall-driven) and the AXI SRAM-like interconnect. Stores are

---
 rtl/sram2sraml_wbuf.sv | 202 ++++++++++++++++++++
 tb/tb_sram2sraml_wbuf.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram2sraml_wbuf.sv
// sram2sraml_wbuf: data-side SRAM -> SRAM-like bridge with a posted-write buffer.
// Stores are queued and retire in the background. Loads wait until the buffer has
// drained and then issue their own request, so a load never overtakes a buffered store.
// A request is launched combinationally from IDLE. If the address is not accepted in
// that cycle, the payload is latched and held stable in REQ until it is.
module sram2sraml_wbuf #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WB_DEPTH    = 4,
  parameter int unsigned POST_WRITES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [3:0]        data_sram_wen,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              wb_empty,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic [31:0]       data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);

  localparam int unsigned PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
  } wb_entry_t;

  // Map byte enables to the SRAM-like size code. A load (0000) is a full word.
  function automatic logic [1:0] size_of(input logic [3:0] wen);
    logic [1:0] s;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: s = 2'b00;
      4'b0011, 4'b1100:                   s = 2'b01;
      default:                            s = 2'b10;
    endcase
    return s;
  endfunction

  wb_entry_t          mem [WB_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic [1:0]         state;
  logic [1:0]         state_nxt;

  wb_entry_t          req_q;
  logic               req_wr_q;
  logic               req_buf_q;

  logic               done;
  logic [31:0]        rdata_save;

  wb_entry_t          pipe_ent;
  wb_entry_t          issue_ent;
  wb_entry_t          cur_ent;
  logic               is_store;
  logic               posted_store;
  logic               buf_full;
  logic               buf_nonempty;
  logic               push;
  logic               pop;
  logic               pipe_own;
  logic               idle_go;
  logic               cur_wr;
  logic               cur_buf;
  logic               accept;
  logic               xfer_done;
  logic               rd_fin;
  logic               load_fin;

  // Source selection, handshake decode and buffer push/pop qualification.
  always_comb begin
    pipe_ent       = '0;
    pipe_ent.addr  = data_sram_addr;
    pipe_ent.wdata = data_sram_wdata;
    pipe_ent.size  = size_of(data_sram_wen);

    is_store     = |data_sram_wen;
    posted_store = data_sram_en & is_store & (POST_WRITES != 0);
    buf_full     = (count == CNT_W'(WB_DEPTH));
    buf_nonempty = (count != '0);

    push     = ~rst & posted_store & ~done & ~buf_full;
    pipe_own = data_sram_en & ~done & ~(is_store & (POST_WRITES != 0));
    idle_go  = ~rst & (state == S_IDLE) & (buf_nonempty | pipe_own);

    issue_ent = buf_nonempty ? mem[rd_ptr] : pipe_ent;
    cur_ent   = (state == S_IDLE) ? issue_ent : req_q;
    cur_wr    = (state == S_IDLE) ? (buf_nonempty | is_store) : req_wr_q;
    cur_buf   = (state == S_IDLE) ? buf_nonempty : req_buf_q;

    data_req  = idle_go | (~rst & (state == S_REQ));
    accept    = data_req & data_addr_ok;
    xfer_done = data_data_ok & ((state == S_WAIT) | accept);
    pop       = accept & cur_buf;
    rd_fin    = xfer_done & ~cur_buf;
    load_fin  = rd_fin & ~cur_wr;
  end

  // Output drive: bus payload, stall and drain status.
  always_comb begin
    data_wr         = cur_wr;
    data_size       = cur_ent.size;
    data_addr       = cur_ent.addr;
    data_wdata      = cur_ent.wdata;
    d_stall         = data_sram_en & ~done & ~push;
    wb_empty        = ~buf_nonempty & (state == S_IDLE);
    data_sram_rdata = rdata_save;
  end

  // Bus FSM next-state: one transaction outstanding at a time.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (idle_go) begin
          if (data_addr_ok) state_nxt = data_data_ok ? S_IDLE : S_WAIT;
          else              state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (data_addr_ok) state_nxt = data_data_ok ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Latch the launched payload so it stays stable through REQ and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      req_wr_q  <= 1'b0;
      req_buf_q <= 1'b0;
    end else if (idle_go) begin
      req_q     <= issue_ent;
      req_wr_q  <= buf_nonempty | is_store;
      req_buf_q <= buf_nonempty;
    end
  end

  // Write-buffer storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_ent;
  end

  // Write-buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Completion flag: blocks re-push / re-issue while another unit holds the pipeline.
  always_ff @(posedge clk) begin
    if (rst)                                 done <= 1'b0;
    else if ((push | rd_fin) & longest_stall) done <= 1'b1;
    else if (~longest_stall)                 done <= 1'b0;
  end

  // Load data register, held until the next load completes.
  always_ff @(posedge clk) begin
    if (rst)           rdata_save <= '0;
    else if (load_fin) rdata_save <= data_rdata;
  end

endmodule

// File: tb/tb_sram2sraml_wbuf.sv
// Directed bench for sram2sraml_wbuf with a simple SRAM-like slave and a request scoreboard.
module tb_sram2sraml_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        wb_empty;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic        ext_stall;
  logic        ao_en;
  logic        same_mode;
  int unsigned lat;
  logic        pend;
  int unsigned lat_cnt;
  logic [31:0] rdata_drv;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_cnt = 0;
  int last_dok_cyc = -10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  sram2sraml_wbuf #(.ADDR_W(32), .WB_DEPTH(4), .POST_WRITES(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wen   (data_sram_wen),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .longest_stall   (longest_stall),
    .wb_empty        (wb_empty),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok)
  );

  always #5 clk = ~clk;

  assign longest_stall = d_stall | ext_stall;
  assign data_addr_ok  = data_req & ao_en;
  assign data_data_ok  = same_mode ? (data_req & data_addr_ok) : (pend && (lat_cnt == 0));
  assign data_rdata    = rdata_drv;

  // Slave: data_ok 'lat' cycles after address acceptance, or same cycle in same_mode.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend    <= 1'b0;
      lat_cnt <= 0;
    end else if (data_req && data_addr_ok && !same_mode) begin
      pend    <= 1'b1;
      lat_cnt <= lat - 1;
    end else if (pend) begin
      if (lat_cnt == 0) pend <= 1'b0;
      else              lat_cnt <= lat_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_size(input logic [3:0] w);
    if (w == 4'b0001 || w == 4'b0010 || w == 4'b0100 || w == 4'b1000) return 2'b00;
    if (w == 4'b0011 || w == 4'b1100) return 2'b01;
    return 2'b10;
  endfunction

  // Monitor: every accepted request must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && data_req && data_addr_ok) begin
      req_cnt++;
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_req observed_addr=%0h expected=none", data_addr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("req_hdr", 128'({data_wr, data_size, data_addr}), 128'({e.wr, e.size, e.addr}));
        if (e.wr) chk("req_wdata", 128'(data_wdata), 128'(e.wdata));
      end
    end
    if (data_data_ok) last_dok_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    sb.push_back('{wr: 1'b1, size: model_size(w), addr: a, wdata: d});
    data_sram_en    = 1'b1;
    data_sram_addr  = a;
    data_sram_wen   = w;
    data_sram_wdata = d;
    forever begin
      @(negedge clk);
      if (!d_stall) begin ok = 1'b1; break; end
      n++;
      if (n >= 40) break;
      tick();
    end
    chk("store_accept", 128'(ok), 128'(1));
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    rdata_drv = d;
    sb.push_back('{wr: 1'b0, size: 2'b10, addr: a, wdata: 32'h0});
    data_sram_en    = 1'b1;
    data_sram_addr  = a;
    data_sram_wen   = 4'b0000;
    data_sram_wdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!d_stall) begin ok = 1'b1; break; end
      n++;
      if (n >= 40) break;
      tick();
    end
    chk("load_complete", 128'(ok), 128'(1));
    chk("load_rdata", 128'(data_sram_rdata), 128'(d));
    chk("load_release_cycle", 128'(cyc), 128'(last_dok_cyc + 1));
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (wb_empty) break;
      n++;
      if (n >= 60) break;
    end
    chk(tag, 128'(wb_empty), 128'(1));
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc0;
    rst = 1'b1; data_sram_en = 1'b0; data_sram_addr = '0; data_sram_wen = '0;
    data_sram_wdata = '0; ext_stall = 1'b0; ao_en = 1'b1; same_mode = 1'b0;
    lat = 1; rdata_drv = '0;

    // Reset behaviour, including a load request pending during reset.
    tick();
    data_sram_en = 1'b1;
    @(negedge clk);
    chk("rst_dstall_en", 128'(d_stall), 128'(1));
    chk("rst_req_low", 128'(data_req), 128'(0));
    tick();
    data_sram_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req", 128'(data_req), 128'(0));
    chk("t1_dstall", 128'(d_stall), 128'(0));
    chk("t1_empty", 128'(wb_empty), 128'(1));
    chk("t1_rdata", 128'(data_sram_rdata), 128'(0));

    // Single posted word store.
    tick();
    do_store(32'h100, 4'b1111, 32'hDEADBEEF, n);
    chk("t2_no_stall", 128'(n), 128'(0));
    tick();
    data_sram_en = 1'b0;
    @(negedge clk);
    chk("t2_req", 128'(data_req), 128'(1));
    chk("t2_wr", 128'(data_wr), 128'(1));
    chk("t2_size", 128'(data_size), 128'(2'b10));
    chk("t2_not_empty", 128'(wb_empty), 128'(0));
    wait_empty("t2_drained");

    // Fill the buffer with the slave refusing addresses, then free one slot.
    tick();
    ao_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h200 + 32'(i * 4), 4'b1111, 32'hA000_0000 + 32'(i), n);
      chk("t3_no_stall", 128'(n), 128'(0));
      tick();
    end
    sb.push_back('{wr: 1'b1, size: 2'b10, addr: 32'h210, wdata: 32'hA000_0004});
    data_sram_addr  = 32'h210;
    data_sram_wdata = 32'hA000_0004;
    @(negedge clk);
    chk("t3_full_stall0", 128'(d_stall), 128'(1));
    tick();
    @(negedge clk);
    chk("t3_full_stall1", 128'(d_stall), 128'(1));
    tick();
    ao_en = 1'b1;
    @(negedge clk);
    chk("t3_full_stall2", 128'(d_stall), 128'(1));
    tick();
    @(negedge clk);
    chk("t3_slot_free", 128'(d_stall), 128'(0));
    tick();
    data_sram_en = 1'b0;
    wait_empty("t3_drained");

    // Byte store then load to the same word: store must go out first.
    tick();
    do_store(32'h100, 4'b0100, 32'h00AB_0000, n);
    chk("t4_no_stall", 128'(n), 128'(0));
    tick();
    do_load(32'h100, 32'h1234_5678);
    tick();
    data_sram_en = 1'b0;
    rdata_drv = 32'h0;
    tick();
    @(negedge clk);
    chk("t4_rdata_held", 128'(data_sram_rdata), 128'(32'h1234_5678));

    // Load with addr_ok and data_ok in the same cycle.
    tick();
    same_mode = 1'b1;
    rc0 = req_cnt;
    do_load(32'h300, 32'hCAFE_F00D);
    chk("t5_idle", 128'(wb_empty), 128'(1));
    chk("t5_no_reissue", 128'(data_req), 128'(0));
    tick();
    data_sram_en = 1'b0;
    @(negedge clk);
    chk("t5_one_req", 128'(req_cnt - rc0), 128'(1));
    same_mode = 1'b0;

    // Half-word store while another unit holds the pipeline for three cycles.
    tick();
    ext_stall = 1'b1;
    rc0 = req_cnt;
    do_store(32'h400, 4'b0011, 32'h0000_BEEF, n);
    chk("t6_no_stall", 128'(n), 128'(0));
    tick();
    @(negedge clk);
    chk("t6_held_nostall1", 128'(d_stall), 128'(0));
    tick();
    @(negedge clk);
    chk("t6_held_nostall2", 128'(d_stall), 128'(0));
    tick();
    ext_stall = 1'b0;
    data_sram_en = 1'b0;
    wait_empty("t6_drained");
    chk("t6_one_push", 128'(req_cnt - rc0), 128'(1));

    // Reset while a write is in WAIT and another sits in the buffer.
    lat = 5;
    tick();
    do_store(32'h500, 4'b1111, 32'h1111_1111, n);
    tick();
    do_store(32'h504, 4'b1111, 32'h2222_2222, n);
    tick();
    data_sram_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_wait_busy", 128'(wb_empty), 128'(0));
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_rst_req", 128'(data_req), 128'(0));
    chk("t6_rst_empty", 128'(wb_empty), 128'(1));
    chk("t6_rst_rdata", 128'(data_sram_rdata), 128'(0));
    chk("t6_rst_dstall", 128'(d_stall), 128'(0));

    // Normal load after reset.
    lat = 1;
    tick();
    do_load(32'h600, 32'h0BAD_CAFE);
    tick();
    data_sram_en = 1'b0;
    wait_empty("final_drained");
    chk("sb_empty_end", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
